serial_mag_comparator: RTL and testbench

- Parametrised, multi-cycle successor to the team's fixed 8-bit combinational magnitude comparator.
- Latches two WIDTH-bit operands on a start pulse and compares them DIGIT bits per cycle, most significant digit first, with early termination on the first differing digit.
- Supports unsigned and two's-complement signed modes.
- Reports a one-hot greater/equal/less result with a done pulse.
- Used where wide operands make a single-cycle comparator too slow or too large.

---
 rtl/serial_mag_comparator_pkg.sv | 19 +
 rtl/serial_mag_comparator_if.sv | 24 ++
 rtl/serial_mag_comparator_digit_compare.sv | 17 +
 rtl/serial_mag_comparator.sv | 98 +++++++++
 tb/tb_serial_mag_comparator.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_mag_comparator_pkg.sv
// rtl/serial_mag_comparator_pkg.sv - shared types, result codes and digit-count helper
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // One-hot result codes, ordered {greater, equal, less}
    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

    function automatic int digit_count(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/serial_mag_comparator_if.sv
// rtl/serial_mag_comparator_if.sv - request/result bundle for the serial comparator
interface serial_mag_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_greater_b;
    logic             a_equal_b;
    logic             a_less_b;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, a_greater_b, a_equal_b, a_less_b
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, a_greater_b, a_equal_b, a_less_b
    );
endinterface

// File: rtl/serial_mag_comparator_digit_compare.sv
// rtl/serial_mag_comparator_digit_compare.sv - combinational unsigned compare of one digit
module digit_compare #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             lt
);

    // Plain unsigned magnitude of a single digit
    always_comb begin
        gt = (a > b);
        lt = (a < b);
    end

endmodule

// File: rtl/serial_mag_comparator.sv
// rtl/serial_mag_comparator.sv - multi-cycle MSB-first magnitude comparator with early exit
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    serial_mag_comparator_if.slave   bus
);

    localparam int NDIG = digit_count(WIDTH, DIGIT);
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_mag_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [KW-1:0]    k_q;
    logic [2:0]       res_q;
    logic             dig_gt;
    logic             dig_lt;
    logic             accept;
    logic             last_digit;

    // Start is honoured in IDLE and, for back-to-back use, in the DONE cycle
    assign accept     = bus.start && (state_q == IDLE || state_q == DONE);
    assign last_digit = (k_q == KW'(NDIG - 1));

    // The current digit is always the top of the shift registers
    digit_compare #(.DIGIT(DIGIT)) u_digit (
        .a  (a_sh[WIDTH-1 -: DIGIT]),
        .b  (b_sh[WIDTH-1 -: DIGIT]),
        .gt (dig_gt),
        .lt (dig_lt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave COMPARE on the first differing digit or after the last one
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = COMPARE;
            COMPARE: if (dig_gt || dig_lt || last_digit) state_d = DONE;
            DONE:    state_d = bus.start ? COMPARE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand shift registers, digit index and sticky result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            k_q   <= '0;
            res_q <= '0;
        end else if (accept) begin
            // Flipping the sign bit maps two's-complement order onto unsigned order
            a_sh  <= bus.signed_mode ? (bus.a ^ SIGN_MASK) : bus.a;
            b_sh  <= bus.signed_mode ? (bus.b ^ SIGN_MASK) : bus.b;
            k_q   <= '0;
            res_q <= '0;
        end else if (state_q == COMPARE) begin
            if (dig_gt) begin
                res_q <= RES_GT;
            end else if (dig_lt) begin
                res_q <= RES_LT;
            end else if (last_digit) begin
                res_q <= RES_EQ;
            end else begin
                k_q  <= k_q + KW'(1);
                a_sh <= a_sh << DIGIT;
                b_sh <= b_sh << DIGIT;
            end
        end
    end

    assign bus.busy        = (state_q == COMPARE);
    assign bus.done        = (state_q == DONE);
    assign bus.a_greater_b = res_q[2];
    assign bus.a_equal_b   = res_q[1];
    assign bus.a_less_b    = res_q[0];

endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb/tb_serial_mag_comparator.sv - randomized self-checking bench for serial_mag_comparator
module tb_serial_mag_comparator;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;
    localparam int WAIT_MAX = 64;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    serial_mag_comparator_if #(.WIDTH(8))  i8 ();
    serial_mag_comparator_if #(.WIDTH(16)) i16 ();

    serial_mag_comparator #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i8)
    );

    serial_mag_comparator #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected result from integer arithmetic; latency from the first differing digit
    task automatic ref_model(input logic [15:0] va, input logic [15:0] vb, input bit s,
                             input int w, input int d, output logic [2:0] res, output int lat);
        longint ia, ib;
        logic [15:0] x;
        int p;
        ia = longint'(va);
        ib = longint'(vb);
        if (s && va[w-1]) ia = ia - (longint'(1) << w);
        if (s && vb[w-1]) ib = ib - (longint'(1) << w);
        res = (ia > ib) ? GT : ((ia < ib) ? LT : EQ);
        x = va ^ vb;
        p = -1;
        for (int i = 0; i < w; i++) if (x[i]) p = i;
        lat = (p < 0) ? (w / d) : ((w - 1 - p) / d + 1);
    endtask

    function automatic logic [2:0] flags(input bit wide);
        return wide ? {i16.a_greater_b, i16.a_equal_b, i16.a_less_b}
                    : {i8.a_greater_b, i8.a_equal_b, i8.a_less_b};
    endfunction

    task automatic drive(input bit wide, input logic st, input logic [15:0] ta,
                         input logic [15:0] tb_v, input bit s);
        if (wide) begin
            i16.start = st; i16.a = ta; i16.b = tb_v; i16.signed_mode = s;
        end else begin
            i8.start = st; i8.a = ta[7:0]; i8.b = tb_v[7:0]; i8.signed_mode = s;
        end
    endtask

    // One comparison: checks latency, busy length, done/busy exclusivity and result
    task automatic do_cmp(input bit wide, input logic [15:0] ta, input logic [15:0] tb_v,
                          input bit s, input bit b2b, input string name);
        logic [2:0] exp_res;
        int exp_lat, cnt, busy_cnt;
        logic dn, bs;
        ref_model(ta, tb_v, s, wide ? 16 : 8, wide ? 4 : 1, exp_res, exp_lat);
        if (!b2b) @(negedge clk);
        drive(wide, 1'b1, ta, tb_v, s);
        @(posedge clk);
        #1;
        drive(wide, 1'b0, ta, tb_v, s);
        cnt = 0;
        busy_cnt = 0;
        dn = wide ? i16.done : i8.done;
        while (!dn && cnt < WAIT_MAX) begin
            bs = wide ? i16.busy : i8.busy;
            if (bs) busy_cnt++;
            @(posedge clk);
            #1;
            cnt++;
            dn = wide ? i16.done : i8.done;
        end
        bs = wide ? i16.busy : i8.busy;
        checks++;
        if (cnt !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, cnt, exp_lat);
        end
        checks++;
        if (busy_cnt !== exp_lat || bs !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: got %0d busy cycles (busy at done=%b), expected %0d (0)",
                     name, busy_cnt, bs, exp_lat);
        end
        checks++;
        if (flags(wide) !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %b, expected %b (a=%h b=%h s=%0b)",
                     name, flags(wide), exp_res, ta, tb_v, s);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({i8.busy, i8.done, flags(1'b0), i16.busy, i16.done, flags(1'b1)} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected all 0",
                     {i8.busy, i8.done, flags(1'b0), i16.busy, i16.done, flags(1'b1)});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({i8.busy, i8.done, flags(1'b0)} !== 5'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b, expected 00000", {i8.busy, i8.done, flags(1'b0)});
        end
    endtask

    task automatic test_unsigned_basic;
        do_cmp(1'b0, 16'h00, 16'h01, 1'b0, 1'b0, "u_00_01");
        @(posedge clk);
        #1;
        checks++;
        if (i8.done !== 1'b0 || flags(1'b0) !== LT) begin
            errors++;
            $display("FAIL done_pulse: got done=%b flags=%b, expected 0 / %b", i8.done, flags(1'b0), LT);
        end
    endtask

    task automatic test_sign;
        do_cmp(1'b0, 16'h80, 16'h7F, 1'b0, 1'b0, "u_80_7f");
        do_cmp(1'b0, 16'h80, 16'h7F, 1'b1, 1'b0, "s_80_7f");
    endtask

    task automatic test_equal_hold;
        do_cmp(1'b0, 16'hA5, 16'hA5, 1'b0, 1'b0, "eq_a5");
        drive(1'b0, 1'b0, 16'h00, 16'hFF, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (flags(1'b0) !== EQ || i8.busy !== 1'b0) begin
            errors++;
            $display("FAIL eq_hold: got flags=%b busy=%b, expected %b / 0", flags(1'b0), i8.busy, EQ);
        end
    endtask

    task automatic test_back_to_back;
        do_cmp(1'b1, 16'h1234, 16'h1244, 1'b0, 1'b0, "w_1234_1244");
        do_cmp(1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b1, "w_b2b_ffff_0000");
    endtask

    task automatic test_busy_ignore;
        int cnt;
        @(negedge clk);
        drive(1'b0, 1'b1, 16'h00, 16'h01, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'h00, 16'h01, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 16'hFF, 16'h00, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'hC3, 16'h3C, 1'b1);
        cnt = 4;
        while (!i8.done && cnt < WAIT_MAX) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checks++;
        if (cnt !== 8 || flags(1'b0) !== LT) begin
            errors++;
            $display("FAIL busy_ignore: got latency=%0d flags=%b, expected 8 / %b", cnt, flags(1'b0), LT);
        end
    endtask

    task automatic test_reset_mid;
        bit saw_done;
        @(negedge clk);
        drive(1'b0, 1'b1, 16'h00, 16'h01, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'h00, 16'h01, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({i8.busy, i8.done, flags(1'b0)} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid: got %b, expected 00000", {i8.busy, i8.done, flags(1'b0)});
        end
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (i8.done) saw_done = 1'b1;
            if (rst_n == 1'b0) rst_n = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got done pulse, expected none");
        end
        do_cmp(1'b0, 16'h3C, 16'h3B, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_random;
        logic [15:0] ra, rb;
        bit wide, s, b2b;
        int mode;
        b2b = 1'b0;
        for (int n = 0; n < 60; n++) begin
            wide = (n % 2) == 1;
            s = $urandom_range(0, 1) == 1;
            ra = 16'($urandom_range(0, 65535));
            mode = $urandom_range(0, 3);
            if (mode == 0) rb = 16'($urandom_range(0, 65535));
            else if (mode == 1) rb = ra;
            else rb = ra ^ (16'h1 << $urandom_range(0, wide ? 15 : 7));
            if (!wide) begin
                ra[15:8] = 8'h0;
                rb[15:8] = 8'h0;
            end
            do_cmp(wide, ra, rb, s, b2b, $sformatf("rand%0d", n));
            b2b = 1'b0;
            if (wide && $urandom_range(0, 1) == 1) begin
                b2b = 1'b1;
                n++;
                ra = 16'($urandom_range(0, 65535));
                rb = 16'($urandom_range(0, 65535));
                do_cmp(1'b1, ra, rb, s, 1'b1, $sformatf("rand_b2b%0d", n));
                b2b = 1'b0;
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_unsigned_basic();
        test_sign();
        test_equal_hold();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
